// File: rtl/arm_ex_pkg.sv
// Shared types for the multi-cycle ARM EX stage: ALU opcodes, EX FSM states and the NZCV flag bundle.
package arm_ex_pkg;

  typedef enum logic [3:0] {
    ALU_AND = 4'h0, ALU_EOR = 4'h1, ALU_SUB = 4'h2, ALU_RSB = 4'h3,
    ALU_ADD = 4'h4, ALU_ADC = 4'h5, ALU_SBC = 4'h6, ALU_RSC = 4'h7,
    ALU_TST = 4'h8, ALU_TEQ = 4'h9, ALU_CMP = 4'hA, ALU_CMN = 4'hB,
    ALU_ORR = 4'hC, ALU_MOV = 4'hD, ALU_BIC = 4'hE, ALU_MVN = 4'hF
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } ex_state_e;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } nzcv_t;

  // Compare/test opcodes only update flags and never write a register.
  function automatic logic alu_writes_rd(alu_op_e op);
    return !(op inside {ALU_TST, ALU_TEQ, ALU_CMP, ALU_CMN});
  endfunction

endpackage

// File: rtl/arm_mac_iter.sv
// Iterative radix-2^RADIX multiply-accumulate datapath with step counter.
// ARM_EX_MUL_EARLY_TERM_EN: finish as soon as the remaining multiplier bits are all zero.
module arm_mac_iter
  import arm_ex_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int RADIX  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic              step_i,
  input  logic              flush_i,
  input  logic [DATA_W-1:0] acc_init_i,
  input  logic [DATA_W-1:0] mcand_i,
  input  logic [DATA_W-1:0] mplier_i,
  output logic              done_o,
  output logic [DATA_W-1:0] acc_o
);

  localparam int STEPS = DATA_W / RADIX;
  localparam int CNT_W = $clog2(STEPS + 1);

  logic [DATA_W-1:0] acc_q, mcand_q, mplier_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [DATA_W-1:0] partial, mplier_nxt;

  assign partial    = mcand_q * DATA_W'(mplier_q[RADIX-1:0]);
  assign mplier_nxt = mplier_q >> RADIX;
  assign acc_o      = acc_q;

  always_comb begin
    done_o = 1'b0;
`ifdef ARM_EX_MUL_EARLY_TERM_EN
    done_o = step_i & ((cnt_q == CNT_W'(STEPS - 1)) | (mplier_nxt == '0));
`else
    done_o = step_i & (cnt_q == CNT_W'(STEPS - 1));
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
    end else if (start_i) begin
      acc_q    <= acc_init_i;
      mcand_q  <= mcand_i;
      mplier_q <= mplier_i;
      cnt_q    <= '0;
    end else if (flush_i) begin
      cnt_q <= '0;
    end else if (step_i) begin
      acc_q    <= acc_q + partial;
      mcand_q  <= mcand_q << RADIX;
      mplier_q <= mplier_nxt;
      cnt_q    <= cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/arm_ex_stage_mc.sv
// Multi-cycle ARM EX stage: single-cycle ALU plus iterative MUL/MLA with ID/MEM handshakes and flush.
// ARM_EX_MUL_EARLY_TERM_EN: a zero multiplier at accept skips straight to DONE.
module arm_ex_stage_mc
  import arm_ex_pkg::*;
#(
  parameter int DATA_W         = 32,
  parameter int MUL_RADIX_BITS = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  output logic              ex_ready,
  input  logic              flush,
  input  logic              id_alu_or_mac,
  input  logic              id_mac_acc_en,
  input  logic [3:0]        id_alu_sel,
  input  logic              id_set_flags,
  input  logic              id_rd_we,
  input  logic [3:0]        id_rd_num,
  input  logic [DATA_W-1:0] id_op1,
  input  logic [DATA_W-1:0] id_op2,
  input  logic              id_shift_cout,
  input  logic [DATA_W-1:0] id_rm,
  input  logic [DATA_W-1:0] id_rs,
  input  logic [3:0]        id_nzcv,
  output logic              ex_busy_valid,
  output logic [3:0]        ex_busy_rd_num,
  output logic              ex_fwd_valid,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic [DATA_W-1:0] mem_data,
  output logic [3:0]        mem_rd_num,
  output logic              mem_rd_we,
  output logic [3:0]        mem_nzcv,
  output logic              mem_nzcv_we
);

  ex_state_e         state_q, state_d;
  logic              slot_free, accept, alu_accept, mac_accept, mac_done, done_write;
  logic [DATA_W-1:0] mac_acc;
  logic              rd_we_q, set_flags_q, c_q, v_q;
  logic [3:0]        rd_q;

  logic              mem_valid_q, mem_rd_we_q, mem_nzcv_we_q;
  logic [DATA_W-1:0] mem_data_q;
  logic [3:0]        mem_rd_num_q;
  nzcv_t             mem_nzcv_q;

  alu_op_e           op;
  nzcv_t             in_nzcv, alu_flags;
  logic [DATA_W-1:0] add_x, add_y, logic_res, alu_res;
  logic              add_cin, is_arith;
  logic [DATA_W:0]   sum;

  assign op        = alu_op_e'(id_alu_sel);
  assign in_nzcv   = nzcv_t'(id_nzcv);
  assign slot_free = !mem_valid_q | mem_ready;
  assign ex_ready  = (state_q == IDLE) & slot_free & !rst;
  assign accept    = id_valid & ex_ready & !flush;
  assign alu_accept = accept & id_alu_or_mac;
  assign mac_accept = accept & !id_alu_or_mac;
  assign done_write = (state_q == DONE) & slot_free & !flush;

  arm_mac_iter #(.DATA_W(DATA_W), .RADIX(MUL_RADIX_BITS)) u_mac (
    .clk        (clk),
    .rst        (rst),
    .start_i    (mac_accept),
    .step_i     ((state_q == MUL) & !flush),
    .flush_i    (flush),
    .acc_init_i (id_mac_acc_en ? id_op1 : '0),
    .mcand_i    (id_rm),
    .mplier_i   (id_rs),
    .done_o     (mac_done),
    .acc_o      (mac_acc)
  );

  // Every arithmetic op is folded into x + y + cin; subtraction inverts one operand.
  always_comb begin
    add_x     = id_op1;
    add_y     = id_op2;
    add_cin   = 1'b0;
    is_arith  = 1'b1;
    logic_res = '0;
    case (op)
      ALU_SUB, ALU_CMP: begin add_y = ~id_op2; add_cin = 1'b1; end
      ALU_RSB:          begin add_x = id_op2; add_y = ~id_op1; add_cin = 1'b1; end
      ALU_ADD, ALU_CMN: ;
      ALU_ADC:          add_cin = in_nzcv.c;
      ALU_SBC:          begin add_y = ~id_op2; add_cin = in_nzcv.c; end
      ALU_RSC:          begin add_x = id_op2; add_y = ~id_op1; add_cin = in_nzcv.c; end
      ALU_AND, ALU_TST: begin is_arith = 1'b0; logic_res = id_op1 & id_op2; end
      ALU_EOR, ALU_TEQ: begin is_arith = 1'b0; logic_res = id_op1 ^ id_op2; end
      ALU_ORR:          begin is_arith = 1'b0; logic_res = id_op1 | id_op2; end
      ALU_MOV:          begin is_arith = 1'b0; logic_res = id_op2; end
      ALU_BIC:          begin is_arith = 1'b0; logic_res = id_op1 & ~id_op2; end
      default:          begin is_arith = 1'b0; logic_res = ~id_op2; end
    endcase
    sum         = {1'b0, add_x} + {1'b0, add_y} + {{DATA_W{1'b0}}, add_cin};
    alu_res     = is_arith ? sum[DATA_W-1:0] : logic_res;
    alu_flags.n = alu_res[DATA_W-1];
    alu_flags.z = (alu_res == '0);
    alu_flags.c = is_arith ? sum[DATA_W] : id_shift_cout;
    alu_flags.v = is_arith ? ((add_x[DATA_W-1] == add_y[DATA_W-1]) &
                              (sum[DATA_W-1] != add_x[DATA_W-1])) : in_nzcv.v;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (mac_accept) begin
`ifdef ARM_EX_MUL_EARLY_TERM_EN
        state_d = (id_rs == '0) ? DONE : MUL;
`else
        state_d = MUL;
`endif
      end
      MUL:     if (flush) state_d = IDLE; else if (mac_done) state_d = DONE;
      DONE:    if (flush | slot_free) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      rd_q        <= '0;
      rd_we_q     <= 1'b0;
      set_flags_q <= 1'b0;
      c_q         <= 1'b0;
      v_q         <= 1'b0;
    end else begin
      state_q <= state_d;
      if (mac_accept) begin
        rd_q        <= id_rd_num;
        rd_we_q     <= id_rd_we;
        set_flags_q <= id_set_flags;
        c_q         <= in_nzcv.c;
        v_q         <= in_nzcv.v;
      end
    end
  end

  // The EX/MEM slot belongs to an older instruction, so flush never clears it.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_valid_q   <= 1'b0;
      mem_data_q    <= '0;
      mem_rd_num_q  <= '0;
      mem_rd_we_q   <= 1'b0;
      mem_nzcv_q    <= '0;
      mem_nzcv_we_q <= 1'b0;
    end else if (alu_accept) begin
      mem_valid_q   <= 1'b1;
      mem_data_q    <= alu_res;
      mem_rd_num_q  <= id_rd_num;
      mem_rd_we_q   <= id_rd_we & alu_writes_rd(op);
      mem_nzcv_q    <= id_set_flags ? alu_flags : in_nzcv;
      mem_nzcv_we_q <= id_set_flags;
    end else if (done_write) begin
      mem_valid_q   <= 1'b1;
      mem_data_q    <= mac_acc;
      mem_rd_num_q  <= rd_q;
      mem_rd_we_q   <= rd_we_q;
      mem_nzcv_q    <= '{n: mac_acc[DATA_W-1], z: (mac_acc == '0), c: c_q, v: v_q};
      mem_nzcv_we_q <= set_flags_q;
    end else if (mem_ready) begin
      mem_valid_q <= 1'b0;
    end
  end

  assign mem_valid      = mem_valid_q;
  assign mem_data       = mem_data_q;
  assign mem_rd_num     = mem_rd_num_q;
  assign mem_rd_we      = mem_rd_we_q;
  assign mem_nzcv       = mem_nzcv_q;
  assign mem_nzcv_we    = mem_nzcv_we_q;
  assign ex_fwd_valid   = mem_valid_q & mem_rd_we_q;
  assign ex_busy_valid  = (state_q != IDLE) & rd_we_q;
  assign ex_busy_rd_num = rd_q;

endmodule

// File: tb/tb_arm_ex_stage_mc.sv
// Randomised self-checking bench for arm_ex_stage_mc against an arithmetic reference model.
// Latency expectations follow ARM_EX_MUL_EARLY_TERM_EN when it is defined.
module tb_arm_ex_stage_mc;

  logic        clk, rst, id_valid, flush, id_alu_or_mac, id_mac_acc_en;
  logic [3:0]  id_alu_sel, id_rd_num, id_nzcv;
  logic        id_set_flags, id_rd_we, id_shift_cout, mem_ready;
  logic [31:0] id_op1, id_op2, id_rm, id_rs;
  logic        ex_ready, ex_busy_valid, ex_fwd_valid, mem_valid, mem_rd_we, mem_nzcv_we;
  logic [3:0]  ex_busy_rd_num, mem_rd_num, mem_nzcv;
  logic [31:0] mem_data;

  int total = 0;
  int bad   = 0;

  arm_ex_stage_mc #(.DATA_W(32), .MUL_RADIX_BITS(2)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .ex_ready(ex_ready), .flush(flush),
    .id_alu_or_mac(id_alu_or_mac), .id_mac_acc_en(id_mac_acc_en), .id_alu_sel(id_alu_sel),
    .id_set_flags(id_set_flags), .id_rd_we(id_rd_we), .id_rd_num(id_rd_num),
    .id_op1(id_op1), .id_op2(id_op2), .id_shift_cout(id_shift_cout),
    .id_rm(id_rm), .id_rs(id_rs), .id_nzcv(id_nzcv),
    .ex_busy_valid(ex_busy_valid), .ex_busy_rd_num(ex_busy_rd_num), .ex_fwd_valid(ex_fwd_valid),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_data(mem_data), .mem_rd_num(mem_rd_num),
    .mem_rd_we(mem_rd_we), .mem_nzcv(mem_nzcv), .mem_nzcv_we(mem_nzcv_we)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    id_valid = 0; flush = 0; id_alu_or_mac = 1; id_mac_acc_en = 0; id_alu_sel = 0;
    id_set_flags = 0; id_rd_we = 0; id_rd_num = 0; id_op1 = 0; id_op2 = 0;
    id_shift_cout = 0; id_rm = 0; id_rs = 0; id_nzcv = 0; mem_ready = 1;
  endtask

  task automatic drive_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic sc, input logic [3:0] nz, input logic sf,
                           input logic we, input logic [3:0] rd);
    id_valid = 1; id_alu_or_mac = 1; id_alu_sel = op; id_op1 = a; id_op2 = b;
    id_shift_cout = sc; id_nzcv = nz; id_set_flags = sf; id_rd_we = we; id_rd_num = rd;
  endtask

  task automatic drive_mac(input logic [31:0] rm, input logic [31:0] rs, input logic [31:0] op1,
                           input logic acc_en, input logic [3:0] nz, input logic sf,
                           input logic we, input logic [3:0] rd);
    id_valid = 1; id_alu_or_mac = 0; id_mac_acc_en = acc_en; id_rm = rm; id_rs = rs;
    id_op1 = op1; id_nzcv = nz; id_set_flags = sf; id_rd_we = we; id_rd_num = rd;
  endtask

  // Reference ALU: exact 64-bit integer arithmetic, flags read off the true result.
  function automatic void alu_model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                    input logic sc, input logic [3:0] nz, input logic sf,
                                    output logic [31:0] res, output logic [3:0] fl, output logic wr);
    longint ua, ub, sa, sb, u, s;
    logic c, v, arith, bi;
    ua = longint'({32'd0, a}); ub = longint'({32'd0, b});
    sa = longint'($signed(a)); sb = longint'($signed(b));
    bi = ~nz[1];
    arith = 1; u = 0; s = 0; c = 0; v = 0; res = 0;
    case (op)
      4'd0, 4'd8:  begin arith = 0; res = a & b; end
      4'd1, 4'd9:  begin arith = 0; res = a ^ b; end
      4'd2, 4'd10: begin u = ua - ub; s = sa - sb; c = (ua >= ub); end
      4'd3:        begin u = ub - ua; s = sb - sa; c = (ub >= ua); end
      4'd4, 4'd11: begin u = ua + ub; s = sa + sb; c = u[32]; end
      4'd5:        begin u = ua + ub + nz[1]; s = sa + sb + nz[1]; c = u[32]; end
      4'd6:        begin u = ua - ub - bi; s = sa - sb - bi; c = (ua >= ub + bi); end
      4'd7:        begin u = ub - ua - bi; s = sb - sa - bi; c = (ub >= ua + bi); end
      4'd12:       begin arith = 0; res = a | b; end
      4'd13:       begin arith = 0; res = b; end
      4'd14:       begin arith = 0; res = a & ~b; end
      default:     begin arith = 0; res = ~b; end
    endcase
    if (arith) begin
      res = u[31:0];
      v = (s != longint'($signed(u[31:0])));
    end else begin
      c = sc;
      v = nz[0];
    end
    fl = sf ? {res[31], (res == 32'd0), c, v} : nz;
    wr = !(op inside {4'd8, 4'd9, 4'd10, 4'd11});
  endfunction

  function automatic int exp_steps(input logic [31:0] rs);
    int n;
    logic [31:0] r;
    n = 16;
`ifdef ARM_EX_MUL_EARLY_TERM_EN
    n = 0;
    r = rs;
    while (r != 0) begin r = r >> 2; n++; end
`else
    r = rs;
`endif
    return n;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'h7FFFFFFF;
      3: return 32'h80000000;
      4: return 32'hFFFFFFFF;
      default: return $urandom;
    endcase
  endfunction

  task automatic test_reset();
    idle_inputs();
    rst = 1;
    drive_alu(4'd4, 32'd1, 32'd1, 0, 4'd0, 1, 1, 4'd3);
    step(); step();
    total++; if (mem_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_mem_valid got=%b exp=0", mem_valid); end
    total++; if (mem_data !== 32'd0) begin bad++; $display("[TB] FAIL reset_mem_data got=%h exp=0", mem_data); end
    total++; if ({mem_nzcv, mem_nzcv_we, mem_rd_we, mem_rd_num} !== 10'd0) begin bad++; $display("[TB] FAIL reset_mem_ctrl got=%h exp=0", {mem_nzcv, mem_nzcv_we, mem_rd_we, mem_rd_num}); end
    total++; if ({ex_busy_valid, ex_fwd_valid} !== 2'b00) begin bad++; $display("[TB] FAIL reset_busy_fwd got=%b exp=00", {ex_busy_valid, ex_fwd_valid}); end
    total++; if (ex_ready !== 1'b0) begin bad++; $display("[TB] FAIL reset_ex_ready got=%b exp=0", ex_ready); end
    idle_inputs();
    rst = 0;
    #1;
    total++; if (ex_ready !== 1'b1) begin bad++; $display("[TB] FAIL post_reset_ready got=%b exp=1", ex_ready); end
  endtask

  task automatic test_alu();
    logic [31:0] a, b, er;
    logic [3:0] op, nz, rd, ef;
    logic sc, sf, we, ew;
    drive_alu(4'd4, 32'h7FFFFFFF, 32'd1, 0, 4'b0000, 1, 1, 4'd3);
    step();
    total++; if (mem_valid !== 1'b1) begin bad++; $display("[TB] FAIL adds_valid got=%b exp=1", mem_valid); end
    total++; if (mem_data !== 32'h80000000) begin bad++; $display("[TB] FAIL adds_data got=%h exp=80000000", mem_data); end
    total++; if ({mem_nzcv, mem_nzcv_we} !== 5'b10011) begin bad++; $display("[TB] FAIL adds_flags got=%b exp=10011", {mem_nzcv, mem_nzcv_we}); end
    // Back-to-back random ALU ops: id_valid stays high every cycle.
    for (int i = 0; i < 40; i++) begin
      op = 4'($urandom_range(0, 15)); a = pick(); b = pick();
      sc = 1'($urandom); nz = 4'($urandom); sf = 1'($urandom); we = 1'($urandom); rd = 4'($urandom);
      drive_alu(op, a, b, sc, nz, sf, we, rd);
      alu_model(op, a, b, sc, nz, sf, er, ef, ew);
      #1;
      total++; if (ex_ready !== 1'b1) begin bad++; $display("[TB] FAIL alu_ready i=%0d got=%b exp=1", i, ex_ready); end
      step();
      total++; if (mem_valid !== 1'b1 || mem_data !== er) begin bad++; $display("[TB] FAIL alu_data op=%0d a=%h b=%h got=%b/%h exp=1/%h", op, a, b, mem_valid, mem_data, er); end
      total++; if ({mem_nzcv, mem_nzcv_we} !== {ef, sf}) begin bad++; $display("[TB] FAIL alu_flags op=%0d a=%h b=%h got=%b exp=%b", op, a, b, {mem_nzcv, mem_nzcv_we}, {ef, sf}); end
      total++; if ({mem_rd_we, mem_rd_num, ex_fwd_valid} !== {we & ew, rd, we & ew}) begin bad++; $display("[TB] FAIL alu_rd op=%0d got=%b exp=%b", op, {mem_rd_we, mem_rd_num, ex_fwd_valid}, {we & ew, rd, we & ew}); end
    end
    id_valid = 0;
    step();
    total++; if (mem_valid !== 1'b0) begin bad++; $display("[TB] FAIL alu_drain got=%b exp=0", mem_valid); end
  endtask

  task automatic test_backpressure();
    drive_alu(4'd4, 32'd100, 32'd23, 0, 4'd0, 0, 1, 4'd2);
    step();
    mem_ready = 0;
    drive_alu(4'd2, 32'd50, 32'd8, 0, 4'd0, 0, 1, 4'd6);
    for (int i = 0; i < 3; i++) begin
      #1;
      total++; if (ex_ready !== 1'b0) begin bad++; $display("[TB] FAIL bp_ready i=%0d got=%b exp=0", i, ex_ready); end
      step();
      total++; if (mem_valid !== 1'b1 || mem_data !== 32'd123 || mem_rd_num !== 4'd2) begin bad++; $display("[TB] FAIL bp_hold i=%0d got=%b/%h/%0d exp=1/7b/2", i, mem_valid, mem_data, mem_rd_num); end
    end
    mem_ready = 1;
    #1;
    total++; if (ex_ready !== 1'b1) begin bad++; $display("[TB] FAIL bp_release_ready got=%b exp=1", ex_ready); end
    step();
    total++; if (mem_data !== 32'd42 || mem_rd_num !== 4'd6) begin bad++; $display("[TB] FAIL bp_next got=%h/%0d exp=2a/6", mem_data, mem_rd_num); end
    id_valid = 0;
    step();
  endtask

  task automatic test_mul();
    int lat, low;
    logic [31:0] rm [2], rs [2], op1 [2];
    logic [3:0]  nz [2], rd [2];
    logic        en [2];
    logic [63:0] full;
    logic [31:0] e;
    rm = '{32'd7, 32'hFFFFFFFF}; rs = '{32'd6, 32'd1}; op1 = '{32'hDEAD, 32'd1};
    en = '{1'b0, 1'b1}; nz = '{4'b0011, 4'b0110}; rd = '{4'd5, 4'd9};
    for (int k = 0; k < 2; k++) begin
      full = 64'(rm[k]) * 64'(rs[k]) + (en[k] ? 64'(op1[k]) : 64'd0);
      e = full[31:0];
      drive_mac(rm[k], rs[k], op1[k], en[k], nz[k], 1, 1, rd[k]);
      step();
      idle_inputs();
      lat = 0; low = 0;
      while (!mem_valid && lat < 200) begin
        if (!ex_ready) begin
          low++;
          total++; if (ex_busy_valid !== 1'b1 || ex_busy_rd_num !== rd[k]) begin bad++; $display("[TB] FAIL mul_busy k=%0d got=%b/%0d exp=1/%0d", k, ex_busy_valid, ex_busy_rd_num, rd[k]); end
        end
        step();
        lat++;
      end
      total++; if (lat !== exp_steps(rs[k]) + 1) begin bad++; $display("[TB] FAIL mul_latency k=%0d got=%0d exp=%0d", k, lat, exp_steps(rs[k]) + 1); end
      total++; if (low !== exp_steps(rs[k]) + 1) begin bad++; $display("[TB] FAIL mul_stall k=%0d got=%0d exp=%0d", k, low, exp_steps(rs[k]) + 1); end
      total++; if (mem_data !== e) begin bad++; $display("[TB] FAIL mul_data k=%0d got=%h exp=%h", k, mem_data, e); end
      total++; if (mem_nzcv !== {e[31], (e == 32'd0), nz[k][1:0]}) begin bad++; $display("[TB] FAIL mul_nzcv k=%0d got=%b exp=%b", k, mem_nzcv, {e[31], (e == 32'd0), nz[k][1:0]}); end
      total++; if ({mem_rd_we, mem_rd_num, mem_nzcv_we} !== {1'b1, rd[k], 1'b1}) begin bad++; $display("[TB] FAIL mul_rd k=%0d got=%b exp=%b", k, {mem_rd_we, mem_rd_num, mem_nzcv_we}, {1'b1, rd[k], 1'b1}); end
      step();
    end
  endtask

  task automatic test_flush();
    int seen;
    drive_alu(4'd13, 32'd0, 32'h55, 0, 4'd0, 0, 1, 4'd1);
    step();
    idle_inputs();
    mem_ready = 0; flush = 1;
    step();
    total++; if (mem_valid !== 1'b1 || mem_data !== 32'h55) begin bad++; $display("[TB] FAIL flush_keeps_mem got=%b/%h exp=1/55", mem_valid, mem_data); end
    flush = 0; mem_ready = 1;
    step();
    drive_alu(4'd4, 32'd1, 32'd2, 0, 4'd0, 0, 1, 4'd1);
    flush = 1;
    step();
    total++; if (mem_valid !== 1'b0) begin bad++; $display("[TB] FAIL flush_kills_accept got=%b exp=0", mem_valid); end
    idle_inputs();
    drive_mac(32'd3, 32'hFFFFFFFF, 32'd0, 0, 4'd0, 1, 1, 4'd7);
    step();
    idle_inputs();
    repeat (4) step();
    flush = 1;
    step();
    flush = 0;
    #1;
    total++; if (ex_ready !== 1'b1 || ex_busy_valid !== 1'b0) begin bad++; $display("[TB] FAIL flush_mul_idle got=%b%b exp=10", ex_ready, ex_busy_valid); end
    seen = 0;
    repeat (20) begin step(); if (mem_valid) seen++; end
    total++; if (seen !== 0) begin bad++; $display("[TB] FAIL flush_mul_nowrite got=%0d exp=0", seen); end
  endtask

  task automatic test_reset_mid_mul();
    int seen;
    drive_alu(4'd13, 32'd0, 32'h1234, 0, 4'd0, 0, 1, 4'd1);
    step();
    drive_mac(32'd9, 32'hFFFFFFFF, 32'd0, 0, 4'd0, 1, 1, 4'd4);
    step();
    idle_inputs();
    step(); step();
    rst = 1;
    step();
    total++; if (mem_valid !== 1'b0 || mem_data !== 32'd0) begin bad++; $display("[TB] FAIL rst_mid_mem got=%b/%h exp=0/0", mem_valid, mem_data); end
    total++; if (ex_busy_valid !== 1'b0 || ex_ready !== 1'b0) begin bad++; $display("[TB] FAIL rst_mid_ctrl got=%b%b exp=00", ex_busy_valid, ex_ready); end
    rst = 0;
    #1;
    total++; if (ex_ready !== 1'b1) begin bad++; $display("[TB] FAIL rst_mid_ready got=%b exp=1", ex_ready); end
    seen = 0;
    repeat (20) begin step(); if (mem_valid) seen++; end
    total++; if (seen !== 0) begin bad++; $display("[TB] FAIL rst_mid_nowrite got=%0d exp=0", seen); end
  endtask

  task automatic test_random_mac();
    int lat;
    logic [31:0] rm, rs, op1, e;
    logic [63:0] full;
    logic [3:0] nz, rd;
    logic en, sf, we;
    for (int i = 0; i < 10; i++) begin
      rm = $urandom; op1 = $urandom; nz = 4'($urandom); rd = 4'($urandom);
      en = 1'($urandom); sf = 1'($urandom); we = 1'($urandom);
      case (i % 3)
        0: rs = $urandom;
        1: rs = 32'($urandom_range(0, 15));
        default: rs = 32'd0;
      endcase
      full = 64'(rm) * 64'(rs) + (en ? 64'(op1) : 64'd0);
      e = full[31:0];
      drive_mac(rm, rs, op1, en, nz, sf, we, rd);
      #1;
      total++; if (ex_ready !== 1'b1) begin bad++; $display("[TB] FAIL mac_ready i=%0d got=%b exp=1", i, ex_ready); end
      step();
      idle_inputs();
      lat = 0;
      while (!mem_valid && lat < 200) begin step(); lat++; end
      total++; if (lat !== exp_steps(rs) + 1) begin bad++; $display("[TB] FAIL mac_latency rs=%h got=%0d exp=%0d", rs, lat, exp_steps(rs) + 1); end
      total++; if (mem_data !== e) begin bad++; $display("[TB] FAIL mac_data rm=%h rs=%h got=%h exp=%h", rm, rs, mem_data, e); end
      total++; if ({mem_nzcv, mem_nzcv_we, mem_rd_we, mem_rd_num} !== {e[31], (e == 32'd0), nz[1:0], sf, we, rd}) begin bad++; $display("[TB] FAIL mac_ctrl i=%0d got=%b exp=%b", i, {mem_nzcv, mem_nzcv_we, mem_rd_we, mem_rd_num}, {e[31], (e == 32'd0), nz[1:0], sf, we, rd}); end
      step();
    end
  endtask

  initial begin
    idle_inputs();
    rst = 1;
    test_reset();
    test_alu();
    test_backpressure();
    test_mul();
    test_flush();
    test_reset_mid_mul();
    test_random_mac();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
